// File: rtl/traffic_phase_ctrl.sv
// Actuated N-approach intersection phase controller: serves demanded approaches
// round-robin through GREEN -> YELLOW -> ALLRED, timed in ticks of a clock divider.
module traffic_phase_ctrl #(
    parameter int NUM_PHASES = 4,
    parameter int TICK_DIV   = 50000000,
    parameter int GREEN_MIN  = 5,
    parameter int GREEN_MAX  = 12,
    parameter int YELLOW_T   = 3,
    parameter int ALLRED_T   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PHASES-1:0]         sensor,
    input  logic                          hold,
    output logic [NUM_PHASES-1:0]         green,
    output logic [NUM_PHASES-1:0]         yellow,
    output logic [NUM_PHASES-1:0]         red,
    output logic [$clog2(NUM_PHASES)-1:0] active_phase,
    output logic [1:0]                    state_code,
    output logic [3:0]                    countdown
);
    localparam int PW = $clog2(NUM_PHASES);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    localparam logic [1:0] S_GREEN  = 2'd0;
    localparam logic [1:0] S_YELLOW = 2'd1;
    localparam logic [1:0] S_ALLRED = 2'd2;

    localparam logic [3:0]            CD_RESET   = 4'((GREEN_MIN > 15) ? 15 : GREEN_MIN);
    localparam logic [NUM_PHASES-1:0] LAMP_RESET = NUM_PHASES'(1);

    logic [1:0]            state_reg, state_next;
    logic [PW-1:0]         phase_reg, phase_next;
    logic [DW-1:0]         div_reg, div_next;
    logic [7:0]            elapsed_reg, elapsed_next;
    logic [NUM_PHASES-1:0] demand_reg, demand_next;
    logic [3:0]            countdown_reg, countdown_next;
    logic [NUM_PHASES-1:0] green_reg, green_next;
    logic [NUM_PHASES-1:0] yellow_reg, yellow_next;
    logic [NUM_PHASES-1:0] red_reg, red_next;

    logic [NUM_PHASES-1:0] is_active;
    logic                  other_demand;
    logic                  go;
    logic                  enter_green;
    int                    e1;

    // Ticks remaining in an interval of kind st after el ticks, clamped to 0..15.
    function automatic logic [3:0] cd_value(input logic [1:0] st, input int el);
        int rem;
        case (st)
            S_GREEN:  rem = GREEN_MIN - el;
            S_YELLOW: rem = YELLOW_T - el;
            default:  rem = ALLRED_T - el;
        endcase
        if (rem < 0)  rem = 0;
        if (rem > 15) rem = 15;
        return rem[3:0];
    endfunction

    function automatic logic [PW-1:0] next_phase(input logic [PW-1:0] cur,
                                                 input logic [NUM_PHASES-1:0] dem);
        logic [PW-1:0] pick;
        logic          found;
        int            idx;
        pick  = cur;
        found = 1'b0;
        for (int k = 1; k < NUM_PHASES; k++) begin
            idx = (int'(cur) + k) % NUM_PHASES;
            if (!found && dem[idx]) begin
                pick  = PW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        div_next       = div_reg;
        elapsed_next   = elapsed_reg;
        countdown_next = countdown_reg;
        go             = 1'b0;
        e1             = int'(elapsed_reg) + 1;
        other_demand   = |(demand_reg & ~is_active);

        if (!hold) begin
            if (div_reg == DIV_LAST) begin
                div_next = '0;
                case (state_reg)
                    S_GREEN:  go = other_demand && (e1 >= GREEN_MIN) &&
                                   (!sensor[phase_reg] || (e1 >= GREEN_MAX));
                    S_YELLOW: go = (e1 == YELLOW_T);
                    default:  go = (e1 == ALLRED_T);
                endcase

                if (go) begin
                    elapsed_next = '0;
                    case (state_reg)
                        S_GREEN:  state_next = S_YELLOW;
                        S_YELLOW: state_next = S_ALLRED;
                        default: begin
                            state_next = S_GREEN;
                            phase_next = next_phase(phase_reg, demand_reg);
                        end
                    endcase
                    countdown_next = cd_value(state_next, 0);
                end else begin
                    elapsed_next   = (elapsed_reg == 8'hFF) ? 8'hFF : elapsed_reg + 8'd1;
                    countdown_next = cd_value(state_reg, int'(elapsed_next));
                end
            end else begin
                div_next = div_reg + DW'(1);
            end
        end

        enter_green = go && (state_reg == S_ALLRED);
    end

    // Demand is never latched for the approach currently holding green; entering green clears it.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PHASES; gi++) begin : g_approach
            assign is_active[gi]   = (phase_reg == PW'(gi));
            assign demand_next[gi] = (enter_green && (phase_next == PW'(gi))) ? 1'b0 :
                                     (demand_reg[gi] |
                                      (sensor[gi] & !((state_reg == S_GREEN) && is_active[gi])));
            assign green_next[gi]  = (state_next == S_GREEN)  && (phase_next == PW'(gi));
            assign yellow_next[gi] = (state_next == S_YELLOW) && (phase_next == PW'(gi));
            assign red_next[gi]    = !(green_next[gi] || yellow_next[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_GREEN;
            phase_reg     <= '0;
            div_reg       <= '0;
            elapsed_reg   <= '0;
            demand_reg    <= '0;
            countdown_reg <= CD_RESET;
            green_reg     <= LAMP_RESET;
            yellow_reg    <= '0;
            red_reg       <= ~LAMP_RESET;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            div_reg       <= div_next;
            elapsed_reg   <= elapsed_next;
            demand_reg    <= demand_next;
            countdown_reg <= countdown_next;
            green_reg     <= green_next;
            yellow_reg    <= yellow_next;
            red_reg       <= red_next;
        end
    end

    assign green        = green_reg;
    assign yellow       = yellow_reg;
    assign red          = red_reg;
    assign active_phase = phase_reg;
    assign state_code   = state_reg;
    assign countdown    = countdown_reg;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them and also watches the lamp invariant.
module tb_traffic_phase_ctrl;
    localparam int NP = 4;
    localparam logic [1:0] G = 2'd0;
    localparam logic [1:0] Y = 2'd1;
    localparam logic [1:0] R = 2'd2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       hold = 1'b0;
    logic [3:0] sensor = 4'b0000;
    logic [3:0] green, yellow, red, countdown;
    logic [1:0] active_phase, state_code;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int scen = 0;

    typedef struct {
        int         cyc;
        int         tag;
        logic [1:0] st;
        logic [1:0] ph;
        logic [3:0] cd;
    } exp_t;

    exp_t q[$];

    traffic_phase_ctrl #(
        .NUM_PHASES(4), .TICK_DIV(4), .GREEN_MIN(3),
        .GREEN_MAX(6), .YELLOW_T(2), .ALLRED_T(1)
    ) dut (
        .clk(clk), .reset(reset), .sensor(sensor), .hold(hold),
        .green(green), .yellow(yellow), .red(red),
        .active_phase(active_phase), .state_code(state_code), .countdown(countdown)
    );

    always #5 clk = ~clk;

    // Cycle N = outputs seen after N clock edges since reset was released.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic push_exp(input int c, input logic [1:0] st, input logic [1:0] ph,
                            input logic [3:0] cd);
        exp_t e;
        e.cyc = c; e.tag = scen; e.st = st; e.ph = ph; e.cd = cd;
        q.push_back(e);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        sensor = 4'b0000;
        hold   = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        int guard = 0;
        while (cyc < c && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic wait_drain();
        int guard = 0;
        while (q.size() > 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain s%0d: %0d expectations left, want 0", scen, q.size());
            q.delete();
        end
        #1;
    endtask

    // Monitor
    initial begin
        exp_t       e;
        logic [3:0] eg, ey, er;
        int         nonred;
        int         onelamp;
        forever begin
            @(negedge clk);
            if (!reset) begin
                nonred  = 0;
                onelamp = 1;
                for (int i = 0; i < NP; i++) begin
                    if (int'(green[i]) + int'(yellow[i]) + int'(red[i]) != 1) onelamp = 0;
                    if (red[i] !== 1'b1) nonred++;
                end
                checks++;
                if (onelamp == 0 || nonred > 1) begin
                    errors++;
                    $display("FAIL lamp_invariant s%0d cyc %0d: got g=%b y=%b r=%b, want one lamp per approach and at most one non-red",
                             scen, cyc, green, yellow, red);
                end
                while (q.size() > 0 && q[0].cyc <= cyc) begin
                    e  = q.pop_front();
                    eg = (e.st == G) ? (4'b0001 << e.ph) : 4'b0000;
                    ey = (e.st == Y) ? (4'b0001 << e.ph) : 4'b0000;
                    er = ~(eg | ey);
                    checks++;
                    if (e.cyc != cyc || green !== eg || yellow !== ey || red !== er ||
                        active_phase !== e.ph || state_code !== e.st || countdown !== e.cd) begin
                        errors++;
                        $display("FAIL s%0d cyc %0d (at %0d): got g=%b y=%b r=%b ph=%0d st=%0d cd=%0d, want g=%b y=%b r=%b ph=%0d st=%0d cd=%0d",
                                 e.tag, e.cyc, cyc, green, yellow, red, active_phase, state_code, countdown,
                                 eg, ey, er, e.ph, e.st, e.cd);
                    end else begin
                        $display("check s%0d cyc %0d ok: g=%b y=%b r=%b ph=%0d st=%0d cd=%0d",
                                 e.tag, e.cyc, green, yellow, red, active_phase, state_code, countdown);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // s1: skip phase 1 to serve 2, then 3, then wrap from 3 to 0
        scen = 1;
        do_reset();
        sensor = 4'b0100;
        push_exp(0, G, 0, 3);   push_exp(3, G, 0, 3);   push_exp(4, G, 0, 2);
        push_exp(8, G, 0, 1);   push_exp(11, G, 0, 1);  push_exp(12, Y, 0, 2);
        push_exp(16, Y, 0, 1);  push_exp(19, Y, 0, 1);  push_exp(20, R, 0, 1);
        push_exp(23, R, 0, 1);  push_exp(24, G, 2, 3);  push_exp(36, G, 2, 0);
        push_exp(40, G, 2, 0);  push_exp(44, Y, 2, 2);  push_exp(52, R, 2, 1);
        push_exp(56, G, 3, 3);  push_exp(68, G, 3, 0);  push_exp(100, G, 3, 0);
        push_exp(104, Y, 3, 2); push_exp(112, R, 3, 1); push_exp(116, G, 0, 3);
        wait_cyc(1);   sensor = 4'b0000;
        wait_cyc(40);  sensor = 4'b1000;
        wait_cyc(41);  sensor = 4'b0000;
        wait_cyc(100); sensor = 4'b0001;
        wait_cyc(101); sensor = 4'b0000;
        wait_drain();

        // s2: no demand, green 0 rests with countdown reaching 0 at cycle 12
        scen = 2;
        do_reset();
        for (int c = 0; c <= 200; c++) begin
            if (c < 13 || c % 20 == 0)
                push_exp(c, G, 0, 4'((c < 4) ? 3 : (c < 8) ? 2 : (c < 12) ? 1 : 0));
        end
        wait_cyc(200);
        wait_drain();

        // s3: sensor 0 held keeps green to GREEN_MAX
        scen = 3;
        do_reset();
        sensor = 4'b0001;
        push_exp(0, G, 0, 3);  push_exp(12, G, 0, 0); push_exp(23, G, 0, 0);
        push_exp(24, Y, 0, 2); push_exp(32, R, 0, 1); push_exp(36, G, 1, 3);
        push_exp(48, G, 1, 0); push_exp(52, G, 1, 0);
        wait_cyc(1);  sensor = 4'b0011;
        wait_cyc(2);  sensor = 4'b0001;
        wait_cyc(24); sensor = 4'b0000;
        wait_drain();

        // s4: sensor 0 dropped at cycle 14 ends green at the next tick
        scen = 4;
        do_reset();
        sensor = 4'b0001;
        push_exp(0, G, 0, 3);  push_exp(12, G, 0, 0); push_exp(14, G, 0, 0);
        push_exp(15, G, 0, 0); push_exp(16, Y, 0, 2);
        wait_cyc(1);  sensor = 4'b0011;
        wait_cyc(2);  sensor = 4'b0001;
        wait_cyc(14); sensor = 4'b0000;
        wait_drain();

        // s5: hold for 40 cycles in yellow; phase 1 demand latched during hold
        scen = 5;
        do_reset();
        sensor = 4'b0100;
        push_exp(0, G, 0, 3);  push_exp(12, Y, 0, 2); push_exp(14, Y, 0, 2);
        push_exp(15, Y, 0, 2); push_exp(16, Y, 0, 2); push_exp(30, Y, 0, 2);
        push_exp(54, Y, 0, 2); push_exp(55, Y, 0, 2); push_exp(56, Y, 0, 1);
        push_exp(59, Y, 0, 1); push_exp(60, R, 0, 1); push_exp(63, R, 0, 1);
        push_exp(64, G, 1, 3); push_exp(76, Y, 1, 2);
        wait_cyc(1);  sensor = 4'b0000;
        wait_cyc(14); hold = 1'b1;
        wait_cyc(30); sensor = 4'b0010;
        wait_cyc(31); sensor = 4'b0000;
        wait_cyc(54); hold = 1'b0;
        wait_drain();

        // s6: reset during yellow of phase 2 with demand pending
        scen = 6;
        do_reset();
        sensor = 4'b0100;
        push_exp(24, G, 2, 3); push_exp(35, G, 2, 1); push_exp(36, Y, 2, 2);
        push_exp(38, Y, 2, 2);
        wait_cyc(1);  sensor = 4'b0000;
        wait_cyc(24); sensor = 4'b0001;
        wait_cyc(25); sensor = 4'b0000;
        wait_cyc(37); sensor = 4'b0010;
        wait_cyc(38); sensor = 4'b0000;
        wait_drain();
        do_reset();
        push_exp(0, G, 0, 3); push_exp(12, G, 0, 0); push_exp(20, G, 0, 0);
        wait_cyc(20);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Parametrised N-approach intersection phase controller. Successor to the fixed two-direction FSM.
- Cycles approaches through GREEN -> YELLOW -> ALLRED using second-based timers from an internal tick divider.
- Actuated by per-approach vehicle sensors: approaches with no demand are skipped; green is extended while its own sensor is active.
- Drives per-approach lamp vectors and a 4-bit countdown for the seven-segment display path.

Parameters:
- NUM_PHASES, 4, number of approaches/phases (2..8).
- TICK_DIV, 50000000, clk cycles per 1 s tick.
- GREEN_MIN, 5, minimum green in ticks (>=1).
- GREEN_MAX, 12, maximum green in ticks (>=GREEN_MIN).
- YELLOW_T, 3, yellow duration in ticks (>=1).
- ALLRED_T, 1, all-red clearance in ticks (>=1).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sensor  in  NUM_PHASES  vehicle presence per approach, active high, already synchronised.
- hold  in  1  manual freeze: timers and state stop.
- green  out  NUM_PHASES  green lamp per approach.
- yellow  out  NUM_PHASES  yellow lamp per approach.
- red  out  NUM_PHASES  red lamp per approach.
- active_phase  out  clog2(NUM_PHASES)  index of the current/last served phase.
- state_code  out  2  0=GREEN, 1=YELLOW, 2=ALLRED.
- countdown  out  4  ticks remaining in the current interval, saturated at 15.

Behaviour:
- Reset (sync, high):
  - state GREEN, active_phase 0, divider 0, elapsed 0, demand 0.
  - green=1 on bit 0 only, yellow=0, red=all ones except bit 0.
  - countdown=min(GREEN_MIN,15).
  - Reset mid-interval returns to exactly this state on the next edge.
- Tick divider:
  - Counts 0..TICK_DIV-1; tick is asserted in the cycle where div==TICK_DIV-1.
  - Divider and elapsed both clear on every state transition, so every interval is an exact multiple of TICK_DIV cycles.
  - elapsed (8 bit) increments on tick and saturates at 255.
- Demand latch demand[p]:
  - Set when sensor[p]=1, unless p is the current GREEN phase.
  - Cleared on the edge where p enters GREEN. Clear wins over set in that cycle.
- Transitions are evaluated only in tick cycles, using e1 = elapsed+1.
- GREEN -> YELLOW when all of the following hold:
  - other demand exists (any demand[q], q != active_phase);
  - e1 >= GREEN_MIN;
  - sensor[active_phase]=0 or e1 >= GREEN_MAX.
  - With no other demand, GREEN rests indefinitely. elapsed keeps saturating; countdown shows 0 once e1 has reached GREEN_MIN.
- YELLOW -> ALLRED when e1 == YELLOW_T.
- ALLRED -> GREEN when e1 == ALLRED_T:
  - The new phase is the first index after active_phase, in round-robin order with wrap from NUM_PHASES-1 to 0, whose demand is 1.
  - If demand was withdrawn meanwhile (cannot happen; latches only clear on service), fall back to active_phase.
- Lamps:
  - GREEN: green[a]=1.
  - YELLOW: yellow[a]=1.
  - ALLRED: all red.
  - All non-active approaches are red. Exactly one lamp per approach is on at all times.
- countdown:
  - GREEN: max(GREEN_MIN-elapsed, 0).
  - YELLOW: YELLOW_T-elapsed.
  - ALLRED: ALLRED_T-elapsed.
  - All values saturate at 15.
  - Registered, updates in the same edge as elapsed.
- hold=1:
  - Divider, elapsed, state, active_phase and outputs are frozen, and no transition occurs.
  - Demand latching continues.
  - On release, counting resumes from the frozen divider value.
- Latency: all outputs are registered. Lamp change appears on the transition edge, with no extra pipeline.
- Invariant: never two approaches non-red simultaneously.

Test Plan:
All scenarios use NUM_PHASES=4, TICK_DIV=4, GREEN_MIN=3, GREEN_MAX=6, YELLOW_T=2, ALLRED_T=1.
- Reset, sensor=4'b0100 for 1 cycle after release -> green[0] for 12 cycles, yellow[0] for 8, all-red 4, then green[2]=1 at cycle 24; phase 1 skipped; demand[2] cleared.
- No sensor activity for 200 cycles -> green[0] stays on, countdown reaches 0 at cycle 12 and stays 0, state_code=0 throughout.
- sensor[0] held high and demand[1] latched at cycle 2 -> green[0] holds until GREEN_MAX: yellow[0] at cycle 24. Dropping sensor[0] at cycle 14 instead -> yellow at cycle 16 (next tick).
- active_phase=3, demand only on phase 0 -> ALLRED then green[0]: wrap-around verified.
- hold=1 for 40 cycles during YELLOW -> lamps, countdown and state unchanged; sensor pulse on phase 1 during hold is latched; after release, YELLOW completes its remaining cycles exactly.
- reset asserted in YELLOW of phase 2 -> next edge: green=4'b0001, red=4'b1110, countdown=3, demand=0.
